// File: rtl/destuffing_pkg.sv
// destuffing_pkg: MAC-wide bit constants and run length shared by stuffing and destuffing
package destuffing_pkg;
  localparam int CAN_RUNLEN = 5;
  localparam logic DOM = 1'b0;
  localparam logic REC = 1'b1;
endpackage

// File: rtl/strobe_edge.sv
// strobe_edge: single-clock eval pulse on the first high clock of a level strobe
module strobe_edge (
  input  logic clock,
  input  logic reset,
  input  logic activ,
  output logic eval
);
  logic edged;
  always_ff @(posedge clock)
    edged <= reset & activ;
  assign eval = activ & ~edged;
endmodule

// File: rtl/destuffing.sv
// destuffing: receive-side run-length tracker flagging stuff bits and stuff errors
module destuffing
  import destuffing_pkg::*;
#(
  parameter int RUNLEN = CAN_RUNLEN
) (
  input  logic clock,
  input  logic reset,
  input  logic bitin,
  input  logic activ,
  input  logic direct,
  output logic bitout,
  output logic stuff,
  output logic stferr
);
  localparam logic [2:0] RL = 3'(RUNLEN);
  logic [2:0] count;
  logic last;
  logic eval;
  strobe_edge u_edge (
    .clock(clock),
    .reset(reset),
    .activ(activ),
    .eval (eval)
  );
  // an empty run or a differing bit both start a new run; it is a stuff bit only after a full run
  always_ff @(posedge clock)
    if (!reset) begin
      count  <= '0;
      last   <= DOM;
      bitout <= REC;
      stuff  <= 1'b0;
      stferr <= 1'b0;
    end else if (eval) begin
      bitout <= bitin;
      stuff  <= 1'b0;
      stferr <= 1'b0;
      if (direct)
        count <= '0;
      else if (count == 3'd0 || bitin != last) begin
        last  <= bitin;
        count <= 3'd1;
        stuff <= count == RL;
      end else if (count == RL) begin
        stferr <= 1'b1;
        count  <= '0;
      end else
        count <= count + 3'd1;
    end
endmodule

// File: tb/tb_destuffing.sv
// tb_destuffing: directed test-plan sequences plus randomized traffic against a bit-history model
module tb_destuffing;
  import destuffing_pkg::*;
  localparam int RL = CAN_RUNLEN;
  logic clock = 1'b0;
  logic reset, bitin, activ, direct;
  logic bitout, stuff, stferr;
  int n_chk = 0;
  int n_fail = 0;
  bit checking = 1'b0;
  bit edged_m = 1'b0;
  bit hist[$];
  logic exp_bitout, exp_stuff, exp_stferr;

  destuffing #(.RUNLEN(RL)) dut (
    .clock (clock),
    .reset (reset),
    .bitin (bitin),
    .activ (activ),
    .direct(direct),
    .bitout(bitout),
    .stuff (stuff),
    .stferr(stferr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // the last RL bits of the current run history are all equal
  function automatic bit full_run();
    int n = hist.size();
    if (n < RL) return 1'b0;
    for (int i = 1; i < RL; i++)
      if (hist[n-1-i] != hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update();
    if (!reset) begin
      edged_m = 1'b0;
      hist.delete();
      exp_bitout = 1'b1;
      exp_stuff  = 1'b0;
      exp_stferr = 1'b0;
      return;
    end
    if (activ && !edged_m) begin
      exp_bitout = bitin;
      exp_stuff  = 1'b0;
      exp_stferr = 1'b0;
      if (direct)
        hist.delete();
      else if (full_run()) begin
        if (bitin != hist[$]) begin
          exp_stuff = 1'b1;
          hist.delete();
          hist.push_back(bitin);
        end else begin
          exp_stferr = 1'b1;
          hist.delete();
        end
      end else
        hist.push_back(bitin);
    end
    edged_m = activ;
  endtask

  task automatic step(input logic r, input logic a, input logic d, input logic b);
    reset  = r;
    activ  = a;
    direct = d;
    bitin  = b;
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic strobe(input logic b, input logic d = 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, d, b);
    step(1'b1, 1'b0, d, b);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clock)
    if (checking) begin
      chk("bitout", bitout, exp_bitout);
      chk("stuff", stuff, exp_stuff);
      chk("stferr", stferr, exp_stferr);
    end

  initial begin
    logic b;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checking = 1'b1;
    chk("reset_bitout", bitout, 1'b1);
    chk("reset_stuff", stuff, 1'b0);
    chk("reset_stferr", stferr, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    // run-length stuff bit followed by a chained stuff bit
    for (int i = 0; i < 5; i++) strobe(1'b0);
    chk("run_no_stuff_5th", stuff, 1'b0);
    strobe(1'b1);
    chk("run_stuff_6th", stuff, 1'b1);
    chk("run_bitout_6th", bitout, 1'b1);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    chk("chain_no_stuff_10th", stuff, 1'b0);
    strobe(1'b0);
    chk("chain_stuff_11th", stuff, 1'b1);
    chk("chain_stferr", stferr, 1'b0);
    // stuff error, then a fresh run starting at the following bit
    do_reset();
    for (int i = 0; i < 5; i++) strobe(1'b1);
    chk("err_none_5th", stferr, 1'b0);
    strobe(1'b1);
    chk("err_6th", stferr, 1'b1);
    strobe(1'b1);
    chk("err_cleared", stferr, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    strobe(1'b0);
    chk("err_restart_stuff", stuff, 1'b1);
    // bypass
    do_reset();
    for (int i = 0; i < 7; i++) begin
      strobe(1'b0, 1'b1);
      chk("byp_stuff", stuff, 1'b0);
      chk("byp_stferr", stferr, 1'b0);
    end
    for (int i = 0; i < 5; i++) strobe(1'b0);
    chk("byp_after_no_stuff", stuff, 1'b0);
    strobe(1'b1);
    chk("byp_after_stuff", stuff, 1'b1);
    // reset mid-run
    do_reset();
    for (int i = 0; i < 3; i++) strobe(1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_reset_bitout", bitout, 1'b1);
    chk("mid_reset_stuff", stuff, 1'b0);
    chk("mid_reset_stferr", stferr, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b0);
    chk("mid_reset_no_stuff_5th", stuff, 1'b0);
    strobe(1'b1);
    chk("mid_reset_stuff_6th", stuff, 1'b1);
    // long strobe with a toggling bit is a single evaluation of its first value
    do_reset();
    for (int i = 0; i < 4; i++) strobe(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, logic'(i % 2));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("wide_bitout", bitout, 1'b0);
    strobe(1'b1);
    chk("wide_stuff", stuff, 1'b1);
    // randomized traffic with run-favouring bits
    b = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 15) b = ~b;
      step(logic'($urandom_range(199) != 0), logic'($urandom_range(1)),
           logic'($urandom_range(19) == 0), b);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
